// File: rtl/bypass_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : bypass_fifo
//  Description : DEPTH-entry FIFO with a zero-latency bypass path when storage
//                is empty, plus an occupancy output. Optional overflow and
//                underflow pulses are enabled by BYPASS_FIFO_ERROR_FLAGS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module bypass_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clock,
    input  logic                         resetn,
    input  logic                         write_enable,
    input  logic [WIDTH-1:0]             write_data,
    output logic                         full,
    input  logic                         read_enable,
    output logic [WIDTH-1:0]             read_data,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   level
`ifdef BYPASS_FIFO_ERROR_FLAGS_EN
    ,
    output logic                         overflow,
    output logic                         underflow
`endif
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = $clog2(DEPTH + 1);
    localparam logic [c_ptr_w-1:0] c_ptr_last = c_ptr_w'(DEPTH - 1);
    localparam logic [c_ptr_w-1:0] c_ptr_zero = '0;
    localparam logic [c_ptr_w-1:0] c_ptr_one  = c_ptr_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_full = c_cnt_w'(DEPTH);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               r_full;

    logic               w_stored;
    logic               w_empty;
    logic               w_wr_acc;
    logic               w_rd_acc;
    logic               w_bypass;
    logic               w_push;
    logic               w_pop;
    logic [c_ptr_w-1:0] w_wr_ptr_next;
    logic [c_ptr_w-1:0] w_rd_ptr_next;
    logic [c_cnt_w-1:0] w_count_next;

    assign w_stored = (r_count != '0);
    assign w_empty  = !w_stored && !write_enable;
    // Full is registered, so a same-cycle read never frees space for a write.
    assign w_wr_acc = write_enable && !r_full;
    assign w_rd_acc = read_enable && !w_empty;
    // Write consumed directly by the read: storage is left untouched.
    assign w_bypass = !w_stored && w_wr_acc && w_rd_acc;
    assign w_push   = w_wr_acc && !w_bypass;
    assign w_pop    = w_rd_acc && !w_bypass;

    always_comb begin
        w_wr_ptr_next = r_wr_ptr;
        w_rd_ptr_next = r_rd_ptr;
        w_count_next  = r_count;
        if (w_push) begin
            w_wr_ptr_next = (r_wr_ptr == c_ptr_last) ? c_ptr_zero : r_wr_ptr + c_ptr_one;
        end
        if (w_pop) begin
            w_rd_ptr_next = (r_rd_ptr == c_ptr_last) ? c_ptr_zero : r_rd_ptr + c_ptr_one;
        end
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + c_cnt_one;
            2'b01:   w_count_next = r_count - c_cnt_one;
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
        end else begin
            r_wr_ptr <= w_wr_ptr_next;
            r_rd_ptr <= w_rd_ptr_next;
            r_count  <= w_count_next;
            r_full   <= (w_count_next == c_cnt_full);
        end
    end

    // Storage contents are don't-care until written, so no reset here.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= write_data;
        end
    end

    assign full      = r_full;
    assign empty     = w_empty;
    assign level     = r_count;
    assign read_data = w_stored ? r_mem[r_rd_ptr] : write_data;

`ifdef BYPASS_FIFO_ERROR_FLAGS_EN
    logic r_overflow;
    logic r_underflow;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= write_enable && r_full;
            r_underflow <= read_enable && w_empty;
        end
    end

    assign overflow  = r_overflow;
    assign underflow = r_underflow;
`endif

endmodule
`default_nettype wire
